// File: rtl/cmd_dispatcher_if.sv
// ---------------------------------------------------------------------------
// cmd_dispatcher_if : FIFO-read, execution-unit and status bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cmd_dispatcher_if #(
    parameter int DATA = 32
);
    logic            fifo_empty;
    logic [DATA-1:0] fifo_data;
    logic            fifo_rd_en;
    logic            exec_start;
    logic [3:0]      exec_op;
    logic [3:0]      exec_dst;
    logic [3:0]      exec_srca;
    logic [3:0]      exec_srcb;
    logic [15:0]     exec_imm;
    logic            exec_done;
    logic            busy;
    logic            halted;
    logic            err_illegal;
    logic            err_timeout;
    logic [15:0]     ops_done;

    modport master (
        input  fifo_empty, fifo_data, exec_done,
        output fifo_rd_en, exec_start, exec_op, exec_dst, exec_srca, exec_srcb,
               exec_imm, busy, halted, err_illegal, err_timeout, ops_done
    );

    modport slave (
        output fifo_empty, fifo_data, exec_done,
        input  fifo_rd_en, exec_start, exec_op, exec_dst, exec_srca, exec_srcb,
               exec_imm, busy, halted, err_illegal, err_timeout, ops_done
    );
endinterface

`default_nettype wire

// File: rtl/cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// cmd_dispatcher : fetches command words from a FIFO, decodes and dispatches
//                  them to an execution unit with timeout supervision
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cmd_dispatcher #(
    parameter int DATA    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    cmd_dispatcher_if.master  bus
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_fetch    = 3'd1;
    localparam logic [2:0] c_st_latch    = 3'd2;
    localparam logic [2:0] c_st_dispatch = 3'd3;
    localparam logic [2:0] c_st_exec     = 3'd4;
    localparam logic [2:0] c_st_halt     = 3'd5;

    // Counter only needs to reach TIMEOUT-1; the abort fires on that cycle.
    localparam int             c_tcw       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_tcw-1:0] c_tcnt_last = c_tcw'(TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [31:0]      r_cmd;
    logic [c_tcw-1:0] r_tcnt;
    logic [15:0]      r_ops_cnt;
    logic             r_err_illegal;
    logic             r_err_timeout;

    logic [3:0] w_op;
    logic       w_is_exec;
    logic       w_is_illegal;
    logic       w_is_halt;

    assign w_op         = r_cmd[31:28];
    assign w_is_exec    = (w_op >= 4'h1) && (w_op <= 4'h9);
    assign w_is_illegal = (w_op >= 4'hA) && (w_op <= 4'hE);
    assign w_is_halt    = (w_op == 4'hF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_cmd         <= '0;
            r_tcnt        <= '0;
            r_ops_cnt     <= '0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (!bus.fifo_empty) r_state <= c_st_fetch;
                end
                c_st_fetch: begin
                    r_state <= c_st_latch;
                end
                c_st_latch: begin
                    r_cmd   <= bus.fifo_data[31:0];
                    r_state <= c_st_dispatch;
                end
                c_st_dispatch: begin
                    r_tcnt <= '0;
                    if (w_is_exec) begin
                        r_state <= c_st_exec;
                    end else if (w_is_halt) begin
                        r_state <= c_st_halt;
                    end else begin
                        if (w_is_illegal) r_err_illegal <= 1'b1;
                        r_state <= c_st_idle;
                    end
                end
                c_st_exec: begin
                    // Completion takes precedence over a coincident timeout.
                    if (bus.exec_done) begin
                        r_ops_cnt <= r_ops_cnt + 16'd1;
                        r_state   <= c_st_idle;
                    end else if (r_tcnt == c_tcnt_last) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= c_st_idle;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                c_st_halt: begin
                    r_state <= c_st_halt;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.fifo_rd_en  = (r_state == c_st_fetch);
    assign bus.exec_start  = (r_state == c_st_dispatch) && w_is_exec;
    assign bus.busy        = (r_state != c_st_idle) && (r_state != c_st_halt);
    assign bus.halted      = (r_state == c_st_halt);
    assign bus.err_illegal = r_err_illegal;
    assign bus.err_timeout = r_err_timeout;
    assign bus.ops_done    = r_ops_cnt;
    assign bus.exec_op     = r_cmd[31:28];
    assign bus.exec_dst    = r_cmd[27:24];
    assign bus.exec_srca   = r_cmd[23:20];
    assign bus.exec_srcb   = r_cmd[19:16];
    assign bus.exec_imm    = r_cmd[15:0];

endmodule

`default_nettype wire

// File: tb/tb_cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_cmd_dispatcher : directed self-checking bench for cmd_dispatcher
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cmd_dispatcher;

    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmd_dispatcher_if #(.DATA(32)) bus ();

    cmd_dispatcher #(.DATA(32), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0] fq[$];
    int cyc        = 0;
    int rd_cnt     = 0;
    int start_cnt  = 0;
    int rd_cyc     = -1;
    int start_cyc  = -1;
    int start_gap  = -1;
    int push_cyc   = 0;
    int done_lat   = 0;
    int done_cd    = 0;
    logic [3:0]  last_op, last_dst, last_srca, last_srcb;
    logic [15:0] last_imm;

    // One clock: FIFO model presents data the cycle after a read strobe,
    // and the execution-unit model answers done_lat cycles after a start.
    task automatic tick();
        logic rd;
        rd = bus.fifo_rd_en;
        @(posedge clk);
        #1;
        cyc++;
        bus.exec_done = 1'b0;
        if (rd && fq.size() > 0) bus.fifo_data = fq.pop_front();
        bus.fifo_empty = (fq.size() == 0);
        if (bus.fifo_rd_en) begin
            rd_cnt++;
            if (rd_cyc < 0) rd_cyc = cyc;
        end
        if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) bus.exec_done = 1'b1;
        end
        if (bus.exec_start) begin
            start_cnt++;
            if (start_cyc >= 0) start_gap = cyc - start_cyc;
            start_cyc = cyc;
            last_op   = bus.exec_op;
            last_dst  = bus.exec_dst;
            last_srca = bus.exec_srca;
            last_srcb = bus.exec_srcb;
            last_imm  = bus.exec_imm;
            if (done_lat > 0) done_cd = done_lat;
        end
    endtask

    task automatic clear_stats();
        rd_cnt = 0; start_cnt = 0; rd_cyc = -1; start_cyc = -1; start_gap = -1;
        done_cd = 0; bus.exec_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_stats();
    endtask

    task automatic push(input logic [31:0] w);
        fq.push_back(w);
        bus.fifo_empty = 1'b0;
        push_cyc = cyc;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++;
        if ({bus.fifo_rd_en, bus.exec_start, bus.busy, bus.halted} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL reset_ctrl: got rd/start/busy/halted=%b required 0000",
                     {bus.fifo_rd_en, bus.exec_start, bus.busy, bus.halted});
        end
        vec_cnt++;
        if ({bus.err_illegal, bus.err_timeout, bus.ops_done} !== 18'h0) begin
            err_cnt++;
            $display("FAIL reset_stat: got errs=%b%b ops=%h required 00/0000",
                     bus.err_illegal, bus.err_timeout, bus.ops_done);
        end
        vec_cnt++;
        if ({bus.exec_op, bus.exec_dst, bus.exec_srca, bus.exec_srcb, bus.exec_imm} !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_fields: got %h required 00000000",
                     {bus.exec_op, bus.exec_dst, bus.exec_srca, bus.exec_srcb, bus.exec_imm});
        end
    endtask

    task automatic test_single_add();
        do_reset();
        done_lat = 4;
        push(32'h1321_00FF);
        for (int i = 0; i < 20 && start_cnt == 0; i++) tick();
        vec_cnt++;
        if (start_cnt == 0) begin
            err_cnt++;
            $display("FAIL add_start_timeout: got no exec_start required one within 20 cycles");
        end
        vec_cnt++;
        if (rd_cyc - push_cyc !== 1 || start_cyc - push_cyc !== 3) begin
            err_cnt++;
            $display("FAIL add_latency: got rd at +%0d start at +%0d required +1/+3",
                     rd_cyc - push_cyc, start_cyc - push_cyc);
        end
        vec_cnt++;
        if ({last_op, last_dst, last_srca, last_srcb, last_imm} !== 32'h1321_00FF) begin
            err_cnt++;
            $display("FAIL add_fields: got %h required 132100ff",
                     {last_op, last_dst, last_srca, last_srcb, last_imm});
        end
        run(3);
        vec_cnt++;
        if (bus.ops_done !== 16'd0 || bus.busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL add_pre_done: got ops=%h busy=%b required 0000/1", bus.ops_done, bus.busy);
        end
        run(10);
        vec_cnt++;
        if (rd_cnt !== 1 || start_cnt !== 1 || bus.ops_done !== 16'd1 || bus.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL add_final: got rd=%0d start=%0d ops=%h busy=%b required 1/1/0001/0",
                     rd_cnt, start_cnt, bus.ops_done, bus.busy);
        end
    endtask

    task automatic test_mixed_stream();
        do_reset();
        done_lat = 3;
        bus.exec_done = 1'b1;
        tick();
        vec_cnt++;
        if (bus.ops_done !== 16'd0) begin
            err_cnt++;
            $display("FAIL stray_done: got ops=%h required 0000", bus.ops_done);
        end
        push(32'h0000_0000);
        push(32'hB000_0000);
        push(32'h2000_0001);
        run(30);
        vec_cnt++;
        if (start_cnt !== 1 || last_op !== 4'h2 || last_imm !== 16'h0001) begin
            err_cnt++;
            $display("FAIL mixed_start: got starts=%0d op=%h imm=%h required 1/2/0001",
                     start_cnt, last_op, last_imm);
        end
        vec_cnt++;
        if (bus.err_illegal !== 1'b1 || bus.err_timeout !== 1'b0 || bus.ops_done !== 16'd1 || rd_cnt !== 3) begin
            err_cnt++;
            $display("FAIL mixed_status: got ill=%b to=%b ops=%h rd=%0d required 1/0/0001/3",
                     bus.err_illegal, bus.err_timeout, bus.ops_done, rd_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        done_lat = 1;
        push(32'h1000_0000);
        push(32'h2000_0000);
        push(32'h3000_0000);
        run(30);
        vec_cnt++;
        if (start_cnt !== 3 || start_gap !== 5 || bus.ops_done !== 16'd3) begin
            err_cnt++;
            $display("FAIL b2b: got starts=%0d gap=%0d ops=%h required 3/5/0003",
                     start_cnt, start_gap, bus.ops_done);
        end
    endtask

    task automatic test_halt();
        do_reset();
        done_lat = 2;
        push(32'hF000_0000);
        push(32'h1000_0000);
        run(110);
        vec_cnt++;
        if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || rd_cnt !== 1 || start_cnt !== 0) begin
            err_cnt++;
            $display("FAIL halt_hold: got halted=%b busy=%b rd=%0d starts=%0d required 1/0/1/0",
                     bus.halted, bus.busy, rd_cnt, start_cnt);
        end
        do_reset();
        vec_cnt++;
        if (bus.halted !== 1'b0) begin
            err_cnt++;
            $display("FAIL halt_reset: got halted=%b required 0", bus.halted);
        end
        run(20);
        vec_cnt++;
        if (rd_cnt !== 1 || start_cnt !== 1 || last_op !== 4'h1 || bus.ops_done !== 16'd1) begin
            err_cnt++;
            $display("FAIL halt_resume: got rd=%0d starts=%0d op=%h ops=%h required 1/1/1/0001",
                     rd_cnt, start_cnt, last_op, bus.ops_done);
        end
    endtask

    task automatic test_timeout();
        int err_cyc;
        do_reset();
        done_lat = 0;
        err_cyc  = -1;
        push(32'h3000_0000);
        for (int i = 0; i < 100 && err_cyc < 0; i++) begin
            tick();
            if (bus.err_timeout === 1'b1) err_cyc = cyc;
        end
        vec_cnt++;
        if (err_cyc < 0 || err_cyc - (start_cyc + 1) !== TO) begin
            err_cnt++;
            $display("FAIL timeout_cycle: got err %0d cycles after EXEC entry required %0d",
                     err_cyc - (start_cyc + 1), TO);
        end
        vec_cnt++;
        if (bus.ops_done !== 16'd0 || bus.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL timeout_state: got ops=%h busy=%b required 0000/0", bus.ops_done, bus.busy);
        end
        done_lat = 2;
        push(32'h4000_0000);
        run(15);
        vec_cnt++;
        if (start_cnt !== 2 || last_op !== 4'h4 || bus.ops_done !== 16'd1 || bus.err_timeout !== 1'b1) begin
            err_cnt++;
            $display("FAIL timeout_next: got starts=%0d op=%h ops=%h to=%b required 2/4/0001/1",
                     start_cnt, last_op, bus.ops_done, bus.err_timeout);
        end
    endtask

    task automatic test_timeout_boundary();
        do_reset();
        done_lat = TO;
        push(32'h5000_0000);
        run(TO + 10);
        vec_cnt++;
        if (bus.ops_done !== 16'd1 || bus.err_timeout !== 1'b0) begin
            err_cnt++;
            $display("FAIL done_wins: got ops=%h to=%b required 0001/0", bus.ops_done, bus.err_timeout);
        end
        done_lat = TO + 1;
        push(32'h6000_0000);
        run(TO + 10);
        vec_cnt++;
        if (bus.ops_done !== 16'd1 || bus.err_timeout !== 1'b1) begin
            err_cnt++;
            $display("FAIL late_done: got ops=%h to=%b required 0001/1", bus.ops_done, bus.err_timeout);
        end
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        done_lat = 0;
        push(32'h1000_0000);
        for (int i = 0; i < 20 && start_cnt == 0; i++) tick();
        run(2);
        vec_cnt++;
        if (bus.busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL midexec_busy: got busy=%b required 1", bus.busy);
        end
        rst = 1'b1;
        bus.exec_done = 1'b1;
        tick();
        rst = 1'b0;
        clear_stats();
        vec_cnt++;
        if ({bus.busy, bus.halted, bus.exec_start, bus.fifo_rd_en, bus.err_illegal, bus.err_timeout} !== 6'b0
            || bus.ops_done !== 16'd0 || bus.exec_op !== 4'h0) begin
            err_cnt++;
            $display("FAIL midexec_reset: got flags=%b ops=%h op=%h required 000000/0000/0",
                     {bus.busy, bus.halted, bus.exec_start, bus.fifo_rd_en, bus.err_illegal, bus.err_timeout},
                     bus.ops_done, bus.exec_op);
        end
        bus.exec_done = 1'b1;
        run(10);
        vec_cnt++;
        if (bus.ops_done !== 16'd0 || rd_cnt !== 0 || start_cnt !== 0) begin
            err_cnt++;
            $display("FAIL midexec_replay: got ops=%h rd=%0d starts=%0d required 0000/0/0",
                     bus.ops_done, rd_cnt, start_cnt);
        end
    endtask

    task automatic test_wrap_and_empty();
        do_reset();
        force dut.r_ops_cnt = 16'hFFFF;
        tick();
        release dut.r_ops_cnt;
        tick();
        vec_cnt++;
        if (bus.ops_done !== 16'hFFFF) begin
            err_cnt++;
            $display("FAIL wrap_preload: got ops=%h required ffff", bus.ops_done);
        end
        done_lat = 1;
        push(32'h7000_0000);
        run(12);
        vec_cnt++;
        if (bus.ops_done !== 16'h0000 || start_cnt !== 1) begin
            err_cnt++;
            $display("FAIL wrap: got ops=%h starts=%0d required 0000/1", bus.ops_done, start_cnt);
        end
        clear_stats();
        run(60);
        vec_cnt++;
        if (rd_cnt !== 0 || bus.busy !== 1'b0 || bus.fifo_empty !== 1'b1) begin
            err_cnt++;
            $display("FAIL empty_hold: got rd=%0d busy=%b required 0/0", rd_cnt, bus.busy);
        end
    endtask

    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = 32'h0;
        bus.exec_done  = 1'b0;
        test_reset();
        test_single_add();
        test_mixed_stream();
        test_back_to_back();
        test_halt();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid_exec();
        test_wrap_and_empty();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
